// File: rtl/e203_lsu_icb_responder_if.sv
// ICB command/response bundle between the LSU-AGU (master) and a memory-side target (slave).
// Carries one command channel and one in-order response channel.
interface e203_lsu_icb_responder_if;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic [1:0]  icb_cmd_size;
  logic        icb_cmd_excl;
  logic        icb_cmd_lock;
  logic        icb_cmd_itag;

  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic        icb_rsp_err;
  logic        icb_rsp_excl_ok;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_itag;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
           icb_cmd_size, icb_cmd_excl, icb_cmd_lock, icb_cmd_itag, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_excl_ok, icb_rsp_rdata,
           icb_rsp_itag
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
           icb_cmd_size, icb_cmd_excl, icb_cmd_lock, icb_cmd_itag, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_excl_ok, icb_rsp_rdata,
           icb_rsp_itag
  );
endinterface

// File: rtl/e203_lsu_icb_responder.sv
// ICB target backing a small word-addressed SRAM window with byte-masked writes,
// LR/SC reservation tracking and an in-order response queue.
module e203_lsu_icb_responder #(
  parameter int          MEM_AW    = 6,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          RSP_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_cmd_stall,
  e203_lsu_icb_responder_if.slave       icb
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic        err;
    logic        excl_ok;
    logic [31:0] rdata;
    logic        itag;
  } rsp_t;

  logic [31:0]       r_mem [2**MEM_AW];
  rsp_t              r_q   [RSP_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_resv_valid;
  logic [MEM_AW-1:0] r_resv_idx;

  logic [31:0]       w_offset;
  logic              w_in_win;
  logic              w_misalign;
  logic              w_err;
  logic [MEM_AW-1:0] w_idx;
  logic              w_resv_hit;
  logic              w_accept;
  logic              w_pop;
  logic              w_rsp_valid;
  logic              w_do_write;
  rsp_t              w_rsp;
  rsp_t              w_head;
  logic              w_unused_lock;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Window is size-aligned, so the offset's low bits double as the alignment bits.
  assign w_offset   = icb.icb_cmd_addr - BASE_ADDR;
  assign w_in_win   = (w_offset[31:MEM_AW+2] == '0);
  assign w_idx      = w_offset[MEM_AW+1:2];
  assign w_resv_hit = r_resv_valid & (r_resv_idx == w_idx);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_misalign = 1'b0;
    case (icb.icb_cmd_size)
      2'd1:    w_misalign = w_offset[0];
      2'd2:    w_misalign = |w_offset[1:0];
      2'd3:    w_misalign = 1'b1;
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_err = ~w_in_win | w_misalign;

  // Ready looks only at the registered count, never at icb_rsp_ready.
  assign icb.icb_cmd_ready = (r_count < CNT_W'(RSP_DEPTH)) & ~cfg_cmd_stall;
  assign w_accept    = icb.icb_cmd_valid & icb.icb_cmd_ready;
  assign w_rsp_valid = (r_count != '0);
  assign w_pop       = w_rsp_valid & icb.icb_rsp_ready;
  assign w_do_write  = w_accept & ~rst & ~icb.icb_cmd_read & ~w_err
                     & (~icb.icb_cmd_excl | w_resv_hit);

  always_comb begin
    w_rsp      = '0;
    w_rsp.itag = icb.icb_cmd_itag;
    w_rsp.err  = w_err;
    if (!w_err) begin
      if (icb.icb_cmd_read) begin
        w_rsp.rdata   = r_mem[w_idx];
        w_rsp.excl_ok = icb.icb_cmd_excl;
      end else begin
        w_rsp.excl_ok = icb.icb_cmd_excl & w_resv_hit;
      end
    end
  end

  // NOTE: SRAM and queue payload are deliberately not reset; reset only clears the
  // pointers/count, and the outputs are gated so stale payload is never visible.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (icb.icb_cmd_wmask[b]) r_mem[w_idx][8*b +: 8] <= icb.icb_cmd_wdata[8*b +: 8];
      end
    end
    if (w_accept && !rst) r_q[r_wptr] <= w_rsp;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_resv_valid <= 1'b0;
      r_resv_idx   <= '0;
    end else begin
      if (w_accept) r_wptr <= ptr_next(r_wptr);
      if (w_pop)    r_rptr <= ptr_next(r_rptr);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_accept) begin
        if (w_err) begin
          r_resv_valid <= 1'b0;
        end else if (icb.icb_cmd_read && icb.icb_cmd_excl) begin
          r_resv_valid <= 1'b1;
          r_resv_idx   <= w_idx;
        end else if (!icb.icb_cmd_read && (icb.icb_cmd_excl || w_resv_hit)) begin
          r_resv_valid <= 1'b0;
        end
      end
    end
  end

  assign w_head              = r_q[r_rptr];
  assign icb.icb_rsp_valid   = w_rsp_valid;
  assign icb.icb_rsp_err     = w_rsp_valid & w_head.err;
  assign icb.icb_rsp_excl_ok = w_rsp_valid & w_head.excl_ok;
  assign icb.icb_rsp_rdata   = {32{w_rsp_valid}} & w_head.rdata;
  assign icb.icb_rsp_itag    = w_rsp_valid & w_head.itag;

  // Lock carries no meaning for a single-target window.
  assign w_unused_lock = icb.icb_cmd_lock;

endmodule
